// File: rtl/al_accel_mem_arbiter.sv
// Round-robin burst arbiter: shares one SoC memory-bus master port among the
// accelerator data movers and sequences each granted burst as word beats.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no owner; arbitrate among req_valid when enb is high
// S_BURST | owner granted; one word beat presented per cycle on mem_*
// S_DONE  | one-cycle req_done pulse to the owner; owner becomes 'last'
module al_accel_mem_arbiter #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     enb,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*LEN_W-1:0]    req_len,
   input  logic [NREQ-1:0]          req_wr,
   output logic [NREQ-1:0]          req_grant,
   output logic [NREQ-1:0]          req_beat,
   output logic [NREQ-1:0]          req_done,
   output logic                     mem_valid,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     mem_we,
   input  logic                     mem_ready,
   output logic                     busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     last_idx;
   logic [IW-1:0]     win_idx;
   logic [ADDR_W-1:0] base_r;
   logic [LEN_W-1:0]  len_r;
   logic              wr_r;
   logic [LEN_W-1:0]  beat_cnt;

   logic [ADDR_W-1:0] addr_arr [NREQ];
   logic [LEN_W-1:0]  len_arr  [NREQ];
   logic              pick_found;
   logic [IW-1:0]     pick_idx;
   int                cand;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[ADDR_W*g +: ADDR_W];
      assign len_arr[g]  = req_len[LEN_W*g +: LEN_W];
   end

   // Rotating search starting one past the previous owner.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(last_idx) + k) % NREQ;
         if (!pick_found && req_valid[IW'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(cand);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req_grant = '0;
      req_done  = '0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (enb && pick_found)
               state_nxt = (len_arr[pick_idx] == '0) ? S_DONE : S_BURST;
         end
         S_BURST: begin
            req_grant[win_idx] = 1'b1;
            mem_valid          = 1'b1;
            mem_addr           = {base_r[ADDR_W-1:2], 2'b00} + ADDR_W'({beat_cnt, 2'b00});
            mem_we             = wr_r;
            if (mem_ready && (beat_cnt == len_r - LEN_W'(1)))
               state_nxt = S_DONE;
         end
         S_DONE: begin
            req_done[win_idx] = 1'b1;
            state_nxt         = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign req_beat = req_grant & {NREQ{mem_ready}};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         last_idx <= IW'(NREQ - 1);
         win_idx  <= '0;
         base_r   <= '0;
         len_r    <= '0;
         wr_r     <= 1'b0;
         beat_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (enb && pick_found) begin
                  win_idx  <= pick_idx;
                  base_r   <= addr_arr[pick_idx];
                  len_r    <= len_arr[pick_idx];
                  wr_r     <= req_wr[pick_idx];
                  beat_cnt <= '0;
               end
            end
            S_BURST: begin
               if (mem_ready)
                  beat_cnt <= beat_cnt + LEN_W'(1);
            end
            S_DONE:  last_idx <= win_idx;
            default: ;
         endcase
      end
   end

endmodule
